// File: rtl/norm_shift_64.sv
// Sequential mantissa normalizer: left-shifts a 64-bit mantissa one byte-scan per
// cycle until bit 63 is set, decrementing the biased exponent by the applied shift.
// The shift is clamped so the exponent never drops below EMIN; a clamped result
// whose top bit is still clear is flagged as denormal.
module norm_shift_64 #(
   parameter int unsigned EXP_W = 11,
   parameter int unsigned EMIN  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [63:0]      in_mant,
   input  logic [EXP_W-1:0] in_exp,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [63:0]      out_mant,
   output logic [EXP_W-1:0] out_exp,
   output logic [6:0]       out_shift,
   output logic             out_zero,
   output logic             out_denorm
);

   typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

   state_e             state_q, state_d;
   logic [63:0]        w_q;
   logic [EXP_W-1:0]   e_q;
   logic [EXP_W-1:0]   b_q;
   logic [6:0]         c_q;

   logic [3:0]         lz;
   logic [3:0]         s;
   logic [63:0]        w_sh;
   logic [6:0]         c_nx;
   logic [EXP_W-1:0]   budget;
   logic               accept;
   logic               out_fire;

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign accept    = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   // Shift budget left before the exponent would reach EMIN.
   assign budget = (in_exp > EXP_W'(EMIN)) ? (in_exp - EXP_W'(EMIN)) : '0;

   // Leading zeros of the top byte; highest set bit wins, 8 if the byte is empty.
   always_comb begin
      lz = 4'd8;
      for (int i = 0; i < 8; i++) begin
         if (w_q[56+i]) lz = 4'(7 - i);
      end
   end

   // Clamp the step to the remaining budget (budget < lz <= 8 fits in 4 bits).
   always_comb begin
      s = lz;
      if (b_q < EXP_W'(lz)) s = b_q[3:0];
      w_sh = w_q << s;
      c_nx = c_q + 7'(s);
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   // Next-state logic; a short step (s < 8) means the scan is finished.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (accept) state_d = (in_mant == 64'd0) ? StDone : StScan;
         end
         StScan: begin
            if (s != 4'd8) state_d = StDone;
         end
         StDone: begin
            if (out_fire) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Working registers and result registers; results are held through DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_q        <= '0;
         e_q        <= '0;
         b_q        <= '0;
         c_q        <= '0;
         out_mant   <= '0;
         out_exp    <= '0;
         out_shift  <= '0;
         out_zero   <= 1'b0;
         out_denorm <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  w_q <= in_mant;
                  e_q <= in_exp;
                  b_q <= budget;
                  c_q <= '0;
                  if (in_mant == 64'd0) begin
                     out_mant   <= '0;
                     out_exp    <= '0;
                     out_shift  <= '0;
                     out_zero   <= 1'b1;
                     out_denorm <= 1'b0;
                  end
               end
            end
            StScan: begin
               w_q <= w_sh;
               c_q <= c_nx;
               b_q <= b_q - EXP_W'(s);
               if (s != 4'd8) begin
                  out_mant   <= w_sh;
                  out_exp    <= e_q - EXP_W'(c_nx);
                  out_shift  <= c_nx;
                  out_zero   <= 1'b0;
                  out_denorm <= ~w_sh[63];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_norm_shift_64.sv
// Self-checking bench for norm_shift_64: directed cases plus randomized operands
// compared against an arithmetic reference model.
module tb_norm_shift_64;

   localparam int unsigned EXP_W = 11;
   localparam int unsigned EMIN  = 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [63:0]      in_mant = '0;
   logic [EXP_W-1:0] in_exp = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [63:0]      out_mant;
   logic [EXP_W-1:0] out_exp;
   logic [6:0]       out_shift;
   logic             out_zero;
   logic             out_denorm;

   int n_checks = 0;
   int n_errors = 0;

   norm_shift_64 #(.EXP_W(EXP_W), .EMIN(EMIN)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_mant    (in_mant),
      .in_exp     (in_exp),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_mant   (out_mant),
      .out_exp    (out_exp),
      .out_shift  (out_shift),
      .out_zero   (out_zero),
      .out_denorm (out_denorm)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: shift = min(leading zeros, exponent headroom above EMIN).
   // One scan cycle per full byte of shift plus the final partial one.
   task automatic model(input logic [63:0] m, input logic [EXP_W-1:0] e,
                        output logic [63:0] rm, output logic [EXP_W-1:0] re,
                        output int rsh, output logic rz, output logic rd, output int rcyc);
      int lz;
      int bud;
      lz = 64;
      for (int i = 0; i < 64; i++) if (m[i]) lz = 63 - i;
      bud = (int'(e) > int'(EMIN)) ? int'(e) - int'(EMIN) : 0;
      if (m == 64'd0) begin
         rm = '0; re = '0; rsh = 0; rz = 1'b1; rd = 1'b0; rcyc = 0;
      end else begin
         rsh  = (lz < bud) ? lz : bud;
         rm   = m << rsh;
         re   = EXP_W'(int'(e) - rsh);
         rz   = 1'b0;
         rd   = ~rm[63];
         rcyc = rsh / 8 + 1;
      end
   endtask

   // Present an operand and return once it has been accepted (#1 after the edge).
   task automatic send(input logic [63:0] m, input logic [EXP_W-1:0] e);
      int guard;
      @(negedge clk);
      in_valid = 1'b1;
      in_mant  = m;
      in_exp   = e;
      guard = 0;
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) begin
         $display("FAIL accept_timeout: in_ready stuck low");
         $fatal(1, "no accept");
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Count cycles from accept to out_valid, then check every result field.
   task automatic wait_check(input logic [63:0] m, input logic [EXP_W-1:0] e, input int hold);
      logic [63:0]      rm;
      logic [EXP_W-1:0] re;
      int               rsh, rcyc, cyc;
      logic             rz, rd;
      model(m, e, rm, re, rsh, rz, rd, rcyc);
      cyc = 0;
      while (!out_valid && cyc < 20) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check("latency", 64'(cyc), 64'(rcyc));
      check("mant", out_mant, rm);
      check("exp", 64'(out_exp), 64'(re));
      check("shift", 64'(out_shift), 64'(rsh));
      check("zero", 64'(out_zero), 64'(rz));
      check("denorm", 64'(out_denorm), 64'(rd));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
      end
      if (hold > 0) begin
         check("hold_valid", 64'(out_valid), 64'd1);
         check("hold_mant", out_mant, rm);
         check("hold_ready", 64'(in_ready), 64'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("post_valid", 64'(out_valid), 64'd0);
      check("post_ready", 64'(in_ready), 64'd1);
   endtask

   task automatic run_op(input logic [63:0] m, input logic [EXP_W-1:0] e, input int hold);
      send(m, e);
      wait_check(m, e, hold);
   endtask

   initial begin
      logic [63:0] m;
      logic [EXP_W-1:0] e;
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_mant", out_mant, 64'd0);
      check("rst_exp", 64'(out_exp), 64'd0);
      check("rst_shift", 64'(out_shift), 64'd0);
      check("rst_flags", {62'd0, out_zero, out_denorm}, 64'd0);
      #22;
      rst_n = 1'b1;

      // Directed cases.
      run_op(64'h0000_0000_0000_0001, 11'd100, 0);
      run_op(64'h0000_0001_0000_0000, 11'd10, 0);
      run_op(64'h8000_0000_0000_0000, 11'd1023, 0);
      run_op(64'd0, 11'd500, 0);
      run_op(64'h00F0_0000_0000_0000, 11'd1, 0);
      run_op(64'h00F0_0000_0000_0000, 11'd0, 0);
      run_op(64'h0000_0000_0000_00FF, 11'd9, 0);

      // Backpressure: a second operand waits on in_valid until the result is taken.
      send(64'h0000_0000_0001_0000, 11'd200);
      @(negedge clk);
      in_valid = 1'b1;
      in_mant  = 64'h0000_0000_0000_0300;
      in_exp   = 11'd60;
      wait_check(64'h0000_0000_0001_0000, 11'd200, 5);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("bp_accept", 64'(in_ready), 64'd0);
      wait_check(64'h0000_0000_0000_0300, 11'd60, 0);

      // Asynchronous reset in the third scan cycle of a long operand.
      send(64'h0000_0000_0000_0001, 11'd100);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 64'(out_valid), 64'd0);
      check("mid_rst_ready", 64'(in_ready), 64'd1);
      check("mid_rst_mant", out_mant, 64'd0);
      check("mid_rst_shift", 64'(out_shift), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) break;
      end
      check("stale_valid", 64'(out_valid), 64'd0);
      run_op(64'h0000_0000_0000_0001, 11'd100, 0);

      // Randomized operands with a spread of leading zeros and small exponents.
      for (int n = 0; n < 60; n++) begin
         m = {$urandom, $urandom} >> $urandom_range(0, 63);
         if ($urandom_range(0, 9) == 0) m = '0;
         if ($urandom_range(0, 1) == 0) e = EXP_W'($urandom_range(0, 70));
         else e = EXP_W'($urandom_range(0, 2047));
         run_op(m, e, $urandom_range(0, 3));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
